// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter sharing one AHB-to-APB bridge slave among several AHB-lite masters.
// Grant handover and all state updates are qualified by the bridge's Hready.
module ahb_bridge_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int MW             = 2,
    parameter int MAX_BEATS      = 8,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   Hclk,
    input  logic                   Hresetn,
    input  logic [NUM_MASTERS-1:0] Hbusreq,
    input  logic [NUM_MASTERS-1:0] Hlock,
    input  logic [1:0]             Htrans,
    input  logic                   Hready,
    output logic [NUM_MASTERS-1:0] Hgrant,
    output logic [MW-1:0]          Hmaster,
    output logic                   Hmastlock
);
    localparam int                     CW         = $clog2(MAX_BEATS + 1);
    localparam logic [1:0]             HTRANS_SEQ = 2'b11;
    localparam logic [MW-1:0]          DEF_IDX    = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT  = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0]          RR_RESET   = MW'((DEFAULT_MASTER + 1) % NUM_MASTERS);
    localparam logic [CW-1:0]          BEAT_MAX   = CW'(MAX_BEATS);
    localparam logic [MW:0]            NM_EXT     = (MW+1)'(NUM_MASTERS);

    typedef enum logic [1:0] {ST_PARK, ST_HANDOVER, ST_OWN, ST_LOCKED} state_t;

    state_t                 state_reg, state_next;
    logic [NUM_MASTERS-1:0] grant_reg, grant_next;
    logic [MW-1:0]          master_reg, master_next;
    logic                   mastlock_reg, mastlock_next;
    logic [CW-1:0]          beat_cnt_reg, beat_cnt_next;
    logic [MW-1:0]          rr_ptr_reg, rr_ptr_next;

    logic [MW-1:0]          grant_idx;
    logic [NUM_MASTERS-1:0] req_masked;
    logic                   found;
    logic [MW-1:0]          winner;
    logic [NUM_MASTERS-1:0] win_onehot;
    logic [MW:0]            winner_inc;
    logic [MW-1:0]          rr_after_win;
    logic [MW-1:0]          cand_idx [NUM_MASTERS];

    assign Hgrant    = grant_reg;
    assign Hmaster   = master_reg;
    assign Hmastlock = mastlock_reg;

    // Candidate order: rr_ptr, rr_ptr+1, ... wrapped modulo NUM_MASTERS.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
            logic [MW:0] sum;
            logic [MW:0] wrapped;
            assign sum     = {1'b0, rr_ptr_reg} + (MW+1)'(gi);
            assign wrapped = sum - NM_EXT;
            assign cand_idx[gi] = (sum >= NM_EXT) ? wrapped[MW-1:0] : sum[MW-1:0];
        end
    endgenerate

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_reg[i]) grant_idx = MW'(i);
        end
    end

    // The current owner never competes against itself outside of park.
    assign req_masked = (state_reg == ST_PARK) ? Hbusreq
                                               : (Hbusreq & ~(NUM_MASTERS'(1) << master_reg));
    assign found = |req_masked;

    always_comb begin
        winner = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req_masked[cand_idx[i]]) winner = cand_idx[i];
        end
    end

    assign win_onehot   = NUM_MASTERS'(1) << winner;
    assign winner_inc   = {1'b0, winner} + (MW+1)'(1);
    assign rr_after_win = (winner_inc >= NM_EXT) ? '0 : winner_inc[MW-1:0];

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_reg    <= ST_PARK;
            grant_reg    <= DEF_GRANT;
            master_reg   <= DEF_IDX;
            mastlock_reg <= 1'b0;
            beat_cnt_reg <= '0;
            rr_ptr_reg   <= RR_RESET;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            master_reg   <= master_next;
            mastlock_reg <= mastlock_next;
            beat_cnt_reg <= beat_cnt_next;
            rr_ptr_reg   <= rr_ptr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        master_next   = master_reg;
        mastlock_next = mastlock_reg;
        beat_cnt_next = beat_cnt_reg;
        rr_ptr_next   = rr_ptr_reg;

        if (Hready) begin
            if (Htrans[1] && (beat_cnt_reg < BEAT_MAX)) beat_cnt_next = beat_cnt_reg + CW'(1);

            unique case (state_reg)
                ST_PARK: begin
                    if (found) begin
                        grant_next  = win_onehot;
                        rr_ptr_next = rr_after_win;
                        state_next  = ST_HANDOVER;
                    end
                end
                ST_HANDOVER: begin
                    master_next   = grant_idx;
                    mastlock_next = Hlock[grant_idx];
                    beat_cnt_next = '0;
                    state_next    = Hlock[grant_idx] ? ST_LOCKED : ST_OWN;
                end
                ST_OWN: begin
                    if (!Hbusreq[master_reg]) begin
                        if (found) begin
                            grant_next  = win_onehot;
                            rr_ptr_next = rr_after_win;
                            state_next  = ST_HANDOVER;
                        end else begin
                            grant_next = DEF_GRANT;
                            state_next = (master_reg == DEF_IDX) ? ST_PARK : ST_HANDOVER;
                        end
                    end else if ((beat_cnt_reg >= BEAT_MAX) && found && (Htrans != HTRANS_SEQ)) begin
                        // Quantum expired; only cut in between bursts.
                        grant_next  = win_onehot;
                        rr_ptr_next = rr_after_win;
                        state_next  = ST_HANDOVER;
                    end else if (Hlock[master_reg]) begin
                        mastlock_next = 1'b1;
                        state_next    = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    mastlock_next = Hlock[master_reg];
                    if (!Hlock[master_reg]) state_next = ST_OWN;
                end
                default: state_next = ST_PARK;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against an index-level
// reference model of the arbitration rules.
module tb_ahb_bridge_arbiter;
    localparam int N        = 4;
    localparam int MWID     = 2;
    localparam int MAXB     = 8;
    localparam int DEF      = 0;
    localparam int PH_PARK  = 0;
    localparam int PH_HAND  = 1;
    localparam int PH_OWN   = 2;
    localparam int PH_LOCK  = 3;

    logic            Hclk;
    logic            Hresetn;
    logic [N-1:0]    Hbusreq;
    logic [N-1:0]    Hlock;
    logic [1:0]      Htrans;
    logic            Hready;
    logic [N-1:0]    Hgrant;
    logic [MWID-1:0] Hmaster;
    logic            Hmastlock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, kept as plain integers.
    int m_grant, m_owner, m_lock, m_next, m_beats, m_phase;

    ahb_bridge_arbiter #(
        .NUM_MASTERS(N), .MW(MWID), .MAX_BEATS(MAXB), .DEFAULT_MASTER(DEF)
    ) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hbusreq(Hbusreq), .Hlock(Hlock),
        .Htrans(Htrans), .Hready(Hready), .Hgrant(Hgrant), .Hmaster(Hmaster),
        .Hmastlock(Hmastlock)
    );

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_grant = DEF;
        m_owner = DEF;
        m_lock  = 0;
        m_next  = (DEF + 1) % N;
        m_beats = 0;
        m_phase = PH_PARK;
    endtask

    function automatic int pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_next + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic grant_to(input int w);
        m_grant = w;
        m_next  = (w + 1) % N;
        m_phase = PH_HAND;
    endtask

    task automatic model_step();
        int nb;
        int prev_owner;
        logic [N-1:0] others;
        if (!Hready) return;
        prev_owner = m_owner;
        nb = (Htrans[1] && m_beats < MAXB) ? m_beats + 1 : m_beats;
        others = Hbusreq & ~(N'(1) << m_owner);
        case (m_phase)
            PH_PARK: if (Hbusreq != '0) grant_to(pick(Hbusreq));
            PH_HAND: begin
                m_owner = m_grant;
                m_lock  = int'(Hlock[m_grant]);
                nb      = 0;
                m_phase = Hlock[m_grant] ? PH_LOCK : PH_OWN;
            end
            PH_OWN: begin
                if (!Hbusreq[m_owner]) begin
                    if (others != '0) grant_to(pick(others));
                    else begin
                        m_grant = DEF;
                        m_phase = (m_owner == DEF) ? PH_PARK : PH_HAND;
                    end
                end else if (m_beats >= MAXB && others != '0 && Htrans != 2'b11) begin
                    grant_to(pick(others));
                end else if (Hlock[m_owner]) begin
                    m_lock  = 1;
                    m_phase = PH_LOCK;
                end
            end
            default: begin
                m_lock = int'(Hlock[m_owner]);
                if (!Hlock[m_owner]) m_phase = PH_OWN;
            end
        endcase
        m_beats = nb;
        if (m_owner != prev_owner)
            $display("txn t=%0t owner M%0d -> M%0d lock=%0d", $time, prev_owner, m_owner, m_lock);
    endtask

    task automatic compare_model();
        check_val("grant", 32'(Hgrant), 32'(1) << m_grant);
        check_val("master", 32'(Hmaster), 32'(m_owner));
        check_val("mastlock", 32'(Hmastlock), 32'(m_lock));
        check_val("onehot", 32'($onehot(Hgrant)), 32'(1));
    endtask

    // Called at a falling edge: apply inputs, let one rising edge pass, compare.
    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lk,
                         input logic [1:0] tr, input logic rdy);
        Hbusreq = req;
        Hlock   = lk;
        Htrans  = tr;
        Hready  = rdy;
        @(posedge Hclk);
        model_step();
        @(negedge Hclk);
        compare_model();
    endtask

    initial begin
        logic [N-1:0] rq;
        logic [N-1:0] lq;
        Hresetn = 1'b0;
        Hbusreq = '0;
        Hlock   = '0;
        Htrans  = 2'b00;
        Hready  = 1'b1;
        model_reset();
        repeat (3) @(negedge Hclk);
        check_val("rst_grant", 32'(Hgrant), 32'h1);
        check_val("rst_master", 32'(Hmaster), 32'h0);
        check_val("rst_mastlock", 32'(Hmastlock), 32'h0);
        Hresetn = 1'b1;

        // Simultaneous request from park: lowest index at/after rr_ptr wins.
        drive(4'b0110, 4'b0000, 2'b00, 1'b1);
        check_val("t2_grant", 32'(Hgrant), 32'b0010);
        check_val("t2_master_hold", 32'(Hmaster), 32'd0);
        drive(4'b0110, 4'b0000, 2'b10, 1'b1);
        check_val("t2_master", 32'(Hmaster), 32'd1);
        drive(4'b0100, 4'b0000, 2'b00, 1'b1);
        check_val("t2_release", 32'(Hgrant), 32'b0100);

        // Wait states during handover freeze everything.
        repeat (5) begin
            drive(4'b0100, 4'b0000, 2'b10, 1'b0);
            check_val("t5_grant", 32'(Hgrant), 32'b0100);
            check_val("t5_master", 32'(Hmaster), 32'd1);
        end
        drive(4'b0100, 4'b0000, 2'b00, 1'b1);
        check_val("t5_master_upd", 32'(Hmaster), 32'd2);

        // Quantum: M2 bursts well past MAX_BEATS, no split while SEQ.
        drive(4'b1100, 4'b0000, 2'b10, 1'b1);
        repeat (11) begin
            drive(4'b1100, 4'b0000, 2'b11, 1'b1);
            check_val("t3_hold", 32'(Hgrant), 32'b0100);
        end
        drive(4'b1100, 4'b0000, 2'b10, 1'b1);
        check_val("t3_preempt", 32'(Hgrant), 32'b1000);
        drive(4'b1000, 4'b0000, 2'b00, 1'b1);
        check_val("t3_master", 32'(Hmaster), 32'd3);

        // Release to park while M3 owns.
        drive(4'b0000, 4'b0000, 2'b00, 1'b1);
        check_val("t6_grant", 32'(Hgrant), 32'b0001);
        check_val("t6_master_hold", 32'(Hmaster), 32'd3);
        drive(4'b0000, 4'b0000, 2'b00, 1'b1);
        check_val("t6_master", 32'(Hmaster), 32'd0);
        drive(4'b0000, 4'b0000, 2'b00, 1'b1);

        // Lock: M1 holds the bus against all others, then one unlocked beat.
        drive(4'b0010, 4'b0000, 2'b00, 1'b1);
        check_val("t4_grant", 32'(Hgrant), 32'b0010);
        drive(4'b0010, 4'b0010, 2'b10, 1'b1);
        repeat (20) begin
            drive(4'b1111, 4'b0010, 2'b10, 1'b1);
            check_val("t4_locked_grant", 32'(Hgrant), 32'b0010);
            check_val("t4_mastlock", 32'(Hmastlock), 32'd1);
        end
        drive(4'b1111, 4'b0000, 2'b10, 1'b1);
        check_val("t4_unlock", 32'(Hmastlock), 32'd0);
        check_val("t4_unlock_grant", 32'(Hgrant), 32'b0010);
        drive(4'b1111, 4'b0000, 2'b10, 1'b1);
        check_val("t4_handover", 32'(Hgrant), 32'b0100);

        // Asynchronous reset in the middle of an M2 burst.
        drive(4'b0100, 4'b0000, 2'b10, 1'b1);
        drive(4'b0100, 4'b0000, 2'b11, 1'b1);
        check_val("t1_pre_master", 32'(Hmaster), 32'd2);
        @(posedge Hclk);
        model_step();
        #2 Hresetn = 1'b0;
        #1;
        check_val("t1_grant", 32'(Hgrant), 32'b0001);
        check_val("t1_master", 32'(Hmaster), 32'd0);
        check_val("t1_mastlock", 32'(Hmastlock), 32'd0);
        model_reset();
        @(negedge Hclk);
        Hresetn = 1'b1;

        // Randomized traffic with sticky requests and locks.
        rq = '0;
        lq = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) rq[i] = ~rq[i];
                if ($urandom_range(0, 11) == 0) lq[i] = ~lq[i];
            end
            if (c == 1500) begin
                @(posedge Hclk);
                #3 Hresetn = 1'b0;
                #1;
                check_val("rnd_rst_grant", 32'(Hgrant), 32'b0001);
                check_val("rnd_rst_master", 32'(Hmaster), 32'd0);
                model_reset();
                @(negedge Hclk);
                Hresetn = 1'b1;
            end
            drive(rq, lq & rq, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
